// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: pairs first-word-fall-through FIFO nibbles into bytes on a valid/ready port,
// padding a trailing odd nibble on flush and counting accepted bytes.
module fifo_nibble_packer #(
  parameter bit               LOW_FIRST   = 1'b1,
  parameter logic [3:0]       PAD_NIBBLE  = 4'h0,
  parameter int               COUNT_WIDTH = 8
) (
  input  logic                   read_clock,
  input  logic                   read_reset,
  input  logic                   empty,
  input  logic [3:0]             read_data,
  output logic                   read_increment,
  input  logic                   flush,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_padded,
  output logic                   partial,
  output logic [COUNT_WIDTH-1:0] byte_count
);
  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;
  logic [NIBBLE_W-1:0] hold;
  logic [NIBBLE_W-1:0] next_nib;
  logic [BYTE_W-1:0]   next_byte;
  logic                flush_pending;
  logic                out_free;
  logic                accept;
  logic                pair_load;
  logic                pad_load;
  logic                load;
  // A pending flush with a held nibble blocks pops so the pad byte goes out next.
  always_comb begin
    out_free       = !out_valid || out_ready;
    accept         = out_valid && out_ready;
    read_increment = !read_reset && !empty && !(partial && flush_pending) && (!partial || out_free);
    pair_load      = read_increment && partial;
    pad_load       = flush_pending && partial && out_free;
    load           = pair_load || pad_load;
    next_nib       = pad_load ? PAD_NIBBLE : read_data;
    next_byte      = LOW_FIRST ? {next_nib, hold} : {hold, next_nib};
  end
  always_ff @(posedge read_clock or posedge read_reset) begin
    if (read_reset) begin
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_padded    <= 1'b0;
      partial       <= 1'b0;
      hold          <= '0;
      flush_pending <= 1'b0;
      byte_count    <= '0;
    end else begin
      if (accept) byte_count <= byte_count + 1'b1;
      if (load) begin
        out_data   <= next_byte;
        out_valid  <= 1'b1;
        out_padded <= pad_load;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (read_increment && !partial) begin
        hold    <= read_data;
        partial <= 1'b1;
      end else if (load) begin
        partial <= 1'b0;
      end
      flush_pending <= flush_pending ? (partial && !pad_load) : flush;
    end
  end
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// tb_fifo_nibble_packer: directed scenarios against two packer configurations fed by queue FIFO models.
module tb_fifo_nibble_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty0, empty1;
  logic [3:0] rd0, rd1;
  logic       inc0, inc1;
  logic       flush0 = 1'b0;
  logic       ready0 = 1'b1;
  logic [7:0] od0, od1;
  logic       ov0, ov1, op0, op1, part0, part1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int         pops0, pops1;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_nibble_packer u0 (
    .read_clock(clk), .read_reset(rst), .empty(empty0), .read_data(rd0),
    .read_increment(inc0), .flush(flush0), .out_data(od0), .out_valid(ov0),
    .out_ready(ready0), .out_padded(op0), .partial(part0), .byte_count(cnt0)
  );

  fifo_nibble_packer #(.LOW_FIRST(1'b0), .PAD_NIBBLE(4'h0), .COUNT_WIDTH(2)) u1 (
    .read_clock(clk), .read_reset(rst), .empty(empty1), .read_data(rd1),
    .read_increment(inc1), .flush(1'b0), .out_data(od1), .out_valid(ov1),
    .out_ready(1'b1), .out_padded(op1), .partial(part1), .byte_count(cnt1)
  );

  task automatic upd();
    empty0 = (q0.size() == 0);
    rd0    = empty0 ? 4'h0 : q0[0];
    empty1 = (q1.size() == 0);
    rd1    = empty1 ? 4'h0 : q1[0];
  endtask

  task automatic step();
    logic i0, i1;
    #1;
    i0 = inc0;
    i1 = inc1;
    @(posedge clk);
    if (i0) begin void'(q0.pop_front()); pops0++; end
    if (i1) begin void'(q1.pop_front()); pops1++; end
    #1;
    upd();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    upd();
    step();
    rst = 1'b0;
    pops0 = 0;
    pops1 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q0 = '{4'h3};
    upd();
    step();
    n_checks++; if (inc0 !== 1'b0) begin n_fail++; $display("FAIL reset_inc: got %b want 0", inc0); end
    n_checks++; if (ov0 !== 1'b0 || od0 !== 8'h00 || op0 !== 1'b0) begin n_fail++; $display("FAIL reset_out: got v%b d%h p%b want v0 d00 p0", ov0, od0, op0); end
    n_checks++; if (part0 !== 1'b0 || cnt0 !== 8'h00) begin n_fail++; $display("FAIL reset_state: got partial %b count %h want 0 00", part0, cnt0); end
  endtask

  task automatic test_pair();
    do_reset();
    ready0 = 1'b1;
    q0 = '{4'h3, 4'hA};
    upd();
    step();
    n_checks++; if (part0 !== 1'b1 || ov0 !== 1'b0) begin n_fail++; $display("FAIL pair_first: got partial %b valid %b want 1 0", part0, ov0); end
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'hA3 || op0 !== 1'b0) begin n_fail++; $display("FAIL pair_byte: got v%b d%h p%b want v1 dA3 p0", ov0, od0, op0); end
    n_checks++; if (part0 !== 1'b0 || pops0 !== 2) begin n_fail++; $display("FAIL pair_pops: got partial %b pops %0d want 0 2", part0, pops0); end
    step();
    n_checks++; if (ov0 !== 1'b0 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL pair_accept: got valid %b count %0d want 0 1", ov0, cnt0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready0 = 1'b0;
    q0 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    upd();
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (pops0 !== 3 || part0 !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got pops %0d partial %b want 3 1", pops0, part0); end
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h21 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL bp_hold: got v%b d%h count %0d want v1 d21 0", ov0, od0, cnt0); end
    ready0 = 1'b1;
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h43 || cnt0 !== 8'd1) begin n_fail++; $display("FAIL bp_second: got v%b d%h count %0d want v1 d43 1", ov0, od0, cnt0); end
    step();
    n_checks++; if (ov0 !== 1'b0 || cnt0 !== 8'd2 || part0 !== 1'b1) begin n_fail++; $display("FAIL bp_gap: got v%b count %0d partial %b want v0 2 1", ov0, cnt0, part0); end
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h65) begin n_fail++; $display("FAIL bp_third: got v%b d%h want v1 d65", ov0, od0); end
    step();
    n_checks++; if (ov0 !== 1'b0 || cnt0 !== 8'd3 || pops0 !== 6) begin n_fail++; $display("FAIL bp_done: got v%b count %0d pops %0d want v0 3 6", ov0, cnt0, pops0); end
  endtask

  task automatic test_flush_odd();
    do_reset();
    ready0 = 1'b1;
    q0 = '{4'h7};
    upd();
    step();
    step();
    n_checks++; if (part0 !== 1'b1 || ov0 !== 1'b0) begin n_fail++; $display("FAIL flush_held: got partial %b valid %b want 1 0", part0, ov0); end
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    n_checks++; if (ov0 !== 1'b0 || u0.flush_pending !== 1'b1) begin n_fail++; $display("FAIL flush_pend: got valid %b pending %b want 0 1", ov0, u0.flush_pending); end
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h07 || op0 !== 1'b1 || part0 !== 1'b0) begin n_fail++; $display("FAIL flush_pad: got v%b d%h p%b partial %b want v1 d07 p1 0", ov0, od0, op0, part0); end
    step();
    n_checks++; if (ov0 !== 1'b0 || cnt0 !== 8'd1 || pops0 !== 1 || inc0 !== 1'b0) begin n_fail++; $display("FAIL flush_after: got v%b count %0d pops %0d inc %b want v0 1 1 0", ov0, cnt0, pops0, inc0); end
  endtask

  task automatic test_flush_idle();
    do_reset();
    ready0 = 1'b1;
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    n_checks++; if (u0.flush_pending !== 1'b1 || ov0 !== 1'b0) begin n_fail++; $display("FAIL idle_set: got pending %b valid %b want 1 0", u0.flush_pending, ov0); end
    step();
    n_checks++; if (u0.flush_pending !== 1'b0 || ov0 !== 1'b0 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL idle_clear: got pending %b valid %b count %0d want 0 0 0", u0.flush_pending, ov0, cnt0); end
    q0 = '{4'h5, 4'h6};
    upd();
    step();
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h65 || op0 !== 1'b0) begin n_fail++; $display("FAIL idle_resume: got v%b d%h p%b want v1 d65 p0", ov0, od0, op0); end
  endtask

  task automatic test_high_first();
    logic [1:0] exp_cnt;
    do_reset();
    for (int i = 0; i < 5; i++) begin q1.push_back(4'h1); q1.push_back(4'h2); end
    upd();
    for (int k = 0; k < 5; k++) begin
      exp_cnt = 2'(k);
      step();
      step();
      n_checks++; if (ov1 !== 1'b1 || od1 !== 8'h12 || cnt1 !== exp_cnt) begin n_fail++; $display("FAIL hi_byte%0d: got v%b d%h count %0d want v1 d12 %0d", k, ov1, od1, cnt1, exp_cnt); end
    end
    step();
    n_checks++; if (ov1 !== 1'b0 || cnt1 !== 2'd1 || pops1 !== 10) begin n_fail++; $display("FAIL hi_wrap: got v%b count %0d pops %0d want v0 1 10", ov1, cnt1, pops1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready0 = 1'b0;
    q0 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    upd();
    step();
    step();
    step();
    n_checks++; if (ov0 !== 1'b1 || part0 !== 1'b1 || od0 !== 8'h21) begin n_fail++; $display("FAIL mid_pre: got v%b partial %b d%h want v1 1 d21", ov0, part0, od0); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ov0 !== 1'b0 || od0 !== 8'h00 || part0 !== 1'b0 || op0 !== 1'b0) begin n_fail++; $display("FAIL mid_async: got v%b d%h partial %b p%b want all 0", ov0, od0, part0, op0); end
    n_checks++; if (inc0 !== 1'b0) begin n_fail++; $display("FAIL mid_inc: got %b want 0", inc0); end
    step();
    n_checks++; if (pops0 !== 3 || inc0 !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got pops %0d inc %b want 3 0", pops0, inc0); end
    rst = 1'b0;
    ready0 = 1'b1;
    step();
    step();
    n_checks++; if (ov0 !== 1'b1 || od0 !== 8'h54 || cnt0 !== 8'd0) begin n_fail++; $display("FAIL mid_resume: got v%b d%h count %0d want v1 d54 0", ov0, od0, cnt0); end
  endtask

  initial begin
    upd();
    test_reset();
    test_pair();
    test_backpressure();
    test_flush_odd();
    test_flush_idle();
    test_high_first();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
